// File: rtl/msx_mouse_pkg.sv
// Shared types and helpers for the MSX mouse port adapter.
// Holds the read-sequence states, the idle pin pattern and the 8-bit saturating clamp.
package msx_mouse_pkg;

    typedef enum logic [1:0] {
        S_XH = 2'd0,
        S_XL = 2'd1,
        S_YH = 2'd2,
        S_YL = 2'd3
    } mouse_state_t;

    localparam logic [5:0] IDLE_PINS = 6'h3F;

    // Clamp a 10-bit signed sum into the MSX 8-bit motion range.
    function automatic logic [7:0] sat8(input logic signed [9:0] v);
        if (v > 10'sd127)
            return 8'h7F;
        else if (v < -10'sd128)
            return 8'h80;
        else
            return v[7:0];
    endfunction

endpackage

// File: rtl/msx_mouse_port_if.sv
// Host-side mouse report inputs, joystick/strobe pins and the port A drive outputs.
// The master side feeds reports and strobes; the slave side is the adapter.
interface msx_mouse_port_if;
    logic signed [8:0] mouse_x;
    logic signed [8:0] mouse_y;
    logic [1:0]        mouse_btn;
    logic              mouse_strobe;
    logic              joy_active;
    logic              stra;
    logic              mouse_en;
    logic [5:0]        port_out;

    modport master (
        output mouse_x, mouse_y, mouse_btn, mouse_strobe, joy_active, stra,
        input  mouse_en, port_out
    );

    modport slave (
        input  mouse_x, mouse_y, mouse_btn, mouse_strobe, joy_active, stra,
        output mouse_en, port_out
    );
endinterface

// File: rtl/msx_mouse_port.sv
// PS/2-style mouse reports to MSX mouse nibble protocol on joystick port A.
// Motion is accumulated with saturation and served as XH,XL,YH,YL nibbles on pin-8 toggles.
module msx_mouse_port
    import msx_mouse_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100000,
    parameter int CNT_W       = 18
) (
    input  logic                clk_sys,
    input  logic                reset,
    msx_mouse_port_if.slave     bus
);

    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(1);

    mouse_state_t     state_q, state_d;
    logic             en_q, en_d;
    logic [5:0]       pins_q, pins_d;
    logic [7:0]       acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic [7:0]       lat_x_q, lat_x_d, lat_y_q, lat_y_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             stra_d;

    logic [7:0]       sum_x, sum_y;
    logic             stra_edge;
    logic             idle;

    // X is inverted: host +right maps to MSX negative X motion.
    always_comb begin
        sum_x = acc_x_q;
        sum_y = acc_y_q;
        if (bus.mouse_strobe) begin
            sum_x = sat8({{2{acc_x_q[7]}}, acc_x_q} - {bus.mouse_x[8], bus.mouse_x});
            sum_y = sat8({{2{acc_y_q[7]}}, acc_y_q} + {bus.mouse_y[8], bus.mouse_y});
        end
    end

    assign stra_edge = bus.stra ^ stra_d;
    // Joystick activity only releases the port when no report arrives in the same cycle.
    assign idle      = !en_q || (bus.joy_active && !bus.mouse_strobe);

    always_comb begin
        en_d    = en_q;
        pins_d  = pins_q;
        state_d = state_q;
        acc_x_d = sum_x;
        acc_y_d = sum_y;
        lat_x_d = lat_x_q;
        lat_y_d = lat_y_q;
        timer_d = timer_q;

        if (bus.mouse_strobe)
            en_d = 1'b1;
        else if (bus.joy_active)
            en_d = 1'b0;

        if (idle) begin
            pins_d  = IDLE_PINS;
            state_d = S_XH;
            timer_d = '0;
            if (!bus.mouse_strobe) begin
                acc_x_d = '0;
                acc_y_d = '0;
            end
        end else begin
            pins_d[5:4] = ~bus.mouse_btn;
            if (stra_edge) begin
                timer_d = TMO_LOAD;
                unique case (state_q)
                    S_XH: begin
                        lat_x_d     = sum_x;
                        lat_y_d     = sum_y;
                        acc_x_d     = '0;
                        acc_y_d     = '0;
                        pins_d[3:0] = sum_x[7:4];
                        state_d     = S_XL;
                    end
                    S_XL: begin
                        pins_d[3:0] = lat_x_q[3:0];
                        state_d     = S_YH;
                    end
                    S_YH: begin
                        pins_d[3:0] = lat_y_q[7:4];
                        state_d     = S_YL;
                    end
                    S_YL: begin
                        pins_d[3:0] = lat_y_q[3:0];
                        state_d     = S_XH;
                    end
                endcase
            end else if (timer_q != '0) begin
                timer_d = timer_q - 1'b1;
                if (timer_q == TMO_LAST)
                    state_d = S_XH;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            en_q    <= 1'b0;
            pins_q  <= IDLE_PINS;
            state_q <= S_XH;
            acc_x_q <= '0;
            acc_y_q <= '0;
            lat_x_q <= '0;
            lat_y_q <= '0;
            timer_q <= '0;
            stra_d  <= 1'b0;
        end else begin
            en_q    <= en_d;
            pins_q  <= pins_d;
            state_q <= state_d;
            acc_x_q <= acc_x_d;
            acc_y_q <= acc_y_d;
            lat_x_q <= lat_x_d;
            lat_y_q <= lat_y_d;
            timer_q <= timer_d;
            stra_d  <= bus.stra;
        end
    end

    assign bus.mouse_en = en_q;
    assign bus.port_out = pins_q;

endmodule
